// File: rtl/pads_cnfg_loader.sv
// Pad output-enable programming front-end: stages a config word by word, then on commit
// pushes changed (or all) pads to the pad stage in groups with settle gaps between them.
module pads_cnfg_loader #(
  parameter int unsigned        NPAD    = 44,
  parameter int unsigned        GRP     = 8,
  parameter int unsigned        SETTLE  = 4,
  parameter logic [NPAD-1:0]    RST_CFG = 44'hC70_003F_FFBD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [1:0]      wr_addr,
  input  logic [31:0]     wr_data,
  input  logic [NPAD-1:0] oe_fb,
  output logic [NPAD-1:0] cnfg_io,
  output logic [NPAD-1:0] cnfg_en,
  output logic            busy,
  output logic            done
);

  localparam int unsigned NGRP = (NPAD + GRP - 1) / GRP;
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE_ST, DONE} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   grp, grp_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [NPAD-1:0] stage, stage_next;
  logic [NPAD-1:0] target, target_next;
  logic [NPAD-1:0] mask, mask_next;
  logic [NPAD-1:0] en_next;
  logic            accept, commit, last_grp;

  // Pads belonging to group g; the final group is naturally clipped at NPAD-1.
  function automatic logic [NPAD-1:0] grp_sel(input logic [GW-1:0] g);
    logic [NPAD-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < NPAD; i++)
      if ((i / GRP) == 32'(g)) sel[i] = 1'b1;
    return sel;
  endfunction

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign cnfg_io = target;

  always_comb begin
    state_next  = state;
    grp_next    = grp;
    cnt_next    = cnt;
    stage_next  = stage;
    target_next = target;
    mask_next   = mask;
    en_next     = '0;
    wr_ready    = (state == IDLE);
    accept      = wr_valid && wr_ready;
    commit      = accept && (wr_addr == 2'd2) && wr_data[0];
    last_grp    = (grp == GW'(NGRP - 1));

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (wr_addr)
            2'd0:    stage_next[31:0]      = wr_data;
            2'd1:    stage_next[NPAD-1:32] = wr_data[NPAD-33:0];
            default: ;
          endcase
        end
        if (commit) begin
          target_next = stage;
          mask_next   = wr_data[1] ? '1 : (stage ^ oe_fb);
          grp_next    = '0;
          state_next  = APPLY;
        end
      end
      APPLY: begin
        if (|(mask & grp_sel(grp))) begin
          cnt_next   = '0;
          state_next = SETTLE_ST;
        end else if (last_grp) begin
          state_next = DONE;
        end else begin
          grp_next = grp + 1'b1;
        end
      end
      SETTLE_ST: begin
        if (cnt == CW'(SETTLE - 1)) begin
          if (last_grp) begin
            state_next = DONE;
          end else begin
            grp_next   = grp + 1'b1;
            state_next = APPLY;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // cnfg_en is registered, so it is loaded with the pulse of the APPLY cycle being entered.
    if (state_next == APPLY) en_next = mask_next & grp_sel(grp_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp     <= '0;
      cnt     <= '0;
      stage   <= RST_CFG;
      target  <= RST_CFG;
      mask    <= '0;
      cnfg_en <= '0;
    end else begin
      grp     <= grp_next;
      cnt     <= cnt_next;
      stage   <= stage_next;
      target  <= target_next;
      mask    <= mask_next;
      cnfg_en <= en_next;
    end
  end

endmodule

// File: tb/tb_pads_cnfg_loader.sv
// Directed bench for pads_cnfg_loader: forced and diff commits, empty commit,
// writes held across a sequence, and reset during a settle window.
module tb_pads_cnfg_loader;

  localparam logic [43:0] RST_CFG = 44'hC70_003F_FFBD;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [43:0] oe_fb;
  logic [43:0] cnfg_io;
  logic [43:0] cnfg_en;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  int          busy_cyc, done_cnt, n_pulse;
  logic [63:0] pulse_val [0:15];
  int          pulse_at  [0:15];

  pads_cnfg_loader #(.NPAD(44), .GRP(8), .SETTLE(4), .RST_CFG(RST_CFG)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .oe_fb(oe_fb), .cnfg_io(cnfg_io),
    .cnfg_en(cnfg_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  // Observe from the cycle after a commit accept until busy drops.
  task automatic run_seq();
    int idx;
    busy_cyc = 0; done_cnt = 0; n_pulse = 0; idx = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      busy_cyc++;
      if (done) done_cnt++;
      if (cnfg_en != '0 && n_pulse < 16) begin
        pulse_val[n_pulse] = 64'(cnfg_en);
        pulse_at[n_pulse]  = idx;
        n_pulse++;
      end
      idx++;
      if (idx > 200) begin
        check("seq_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  function automatic logic [63:0] force_pulse(input int g);
    logic [63:0] v;
    v = (g < 5) ? (64'hFF << (8 * g)) : (64'hF << 40);
    return v;
  endfunction

  initial begin
    int ready_bad, io_bad, idx, extra_en, extra_done;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; oe_fb = RST_CFG;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cnfg_io",  64'(cnfg_io),  64'(RST_CFG));
    check("rst_cnfg_en",  64'(cnfg_en),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_done",     64'(done),     64'd0);
    reset = 1'b0;

    // Forced commit: every group pulses, 5 cycles apart.
    write(2'd2, 32'd3);
    run_seq();
    check("force_busy",   64'(busy_cyc), 64'd31);
    check("force_done",   64'(done_cnt), 64'd1);
    check("force_npulse", 64'(n_pulse),  64'd6);
    for (int g = 0; g < 6; g++) begin
      check("force_pulse_val", pulse_val[g], force_pulse(g));
      check("force_pulse_at",  64'(pulse_at[g]), 64'(5 * g));
    end
    check("force_io", 64'(cnfg_io), 64'(RST_CFG));

    // Diff commit: only pads 0 and 43 differ from the feedback.
    write(2'd0, 32'h003F_FFBC);
    write(2'd1, 32'hFFFF_F470);
    oe_fb = RST_CFG;
    write(2'd2, 32'd1);
    run_seq();
    check("diff_busy",   64'(busy_cyc), 64'd15);
    check("diff_done",   64'(done_cnt), 64'd1);
    check("diff_npulse", 64'(n_pulse),  64'd2);
    check("diff_p0",     pulse_val[0],  64'h1);
    check("diff_p0_at",  64'(pulse_at[0]), 64'd0);
    check("diff_p1",     pulse_val[1],  64'h800_0000_0000);
    check("diff_p1_at",  64'(pulse_at[1]), 64'd9);
    check("diff_io",     64'(cnfg_io),  64'h470_003F_FFBC);

    // Stage equals feedback: no pulses at all.
    oe_fb = 44'h470_003F_FFBC;
    write(2'd2, 32'd1);
    run_seq();
    check("empty_busy",   64'(busy_cyc), 64'd7);
    check("empty_done",   64'(done_cnt), 64'd1);
    check("empty_npulse", 64'(n_pulse),  64'd0);

    // Stage write held during a sequence waits for IDLE and leaves target alone.
    write(2'd2, 32'd3);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 32'h1234_5678;
    ready_bad = 0; io_bad = 0; busy_cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      busy_cyc++;
      if (wr_ready) ready_bad++;
      if (cnfg_io !== 44'h470_003F_FFBC) io_bad++;
      if (busy_cyc > 200) begin
        check("hold_timeout", 64'd1, 64'd0);
        break;
      end
    end
    check("hold_busy",      64'(busy_cyc),  64'd31);
    check("hold_ready_low", 64'(ready_bad), 64'd0);
    check("hold_io_stable", 64'(io_bad),    64'd0);
    check("hold_ready_idle", 64'(wr_ready), 64'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    write(2'd2, 32'd1);
    run_seq();
    check("held_io",   64'(cnfg_io),  64'h470_1234_5678);
    check("held_busy", 64'(busy_cyc), 64'd23);

    // Reset in the settle window of group 2.
    write(2'd2, 32'd3);
    idx = 0;
    forever begin
      @(negedge clk);
      if (idx == 10) check("abort_g2_pulse", 64'(cnfg_en), 64'hFF_0000);
      if (idx == 12) break;
      idx++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_en",       64'(cnfg_en),  64'd0);
    check("abort_done",     64'(done),     64'd0);
    check("abort_io",       64'(cnfg_io),  64'(RST_CFG));
    check("abort_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    extra_en = 0; extra_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (cnfg_en != '0) extra_en++;
      if (done) extra_done++;
    end
    check("abort_no_en",   64'(extra_en),   64'd0);
    check("abort_no_done", 64'(extra_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
